// File: rtl/rotor_pkg.sv
// rotor_pkg: constants and types shared by the rotor stages.
package rotor_pkg;
   localparam int ALPHA = 26;
   localparam logic [4:0] INVALID_LETTER = 5'd31;
   localparam logic [4:0] ROTOR2_FWD [26] = '{
      5'd6, 5'd11, 5'd16, 5'd24, 5'd22, 5'd1, 5'd19, 5'd8, 5'd25, 5'd3, 5'd15, 5'd18, 5'd5,
      5'd10, 5'd0, 5'd13, 5'd9, 5'd2, 5'd20, 5'd23, 5'd17, 5'd4, 5'd21, 5'd12, 5'd14, 5'd7};
   typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/rotor2_inv_table.sv
// rotor2_inv_table: builds the rotor II inverse wiring after reset and serves lookups.
module rotor2_inv_table import rotor_pkg::*; #(
   parameter int ALPHA = 26,
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] rd_addr,
   output logic [W-1:0] rd_data,
   output logic         init_done
);
   state_t state, state_nxt;
   logic [W-1:0] i;
   logic [W-1:0] inv [ALPHA];
   logic last;
   assign last = i == W'(ALPHA - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         i <= '0;
      end else begin
         state <= state_nxt;
         i <= (state == INIT && !last) ? i + 1'b1 : '0;
      end
   end
   always_comb begin
      state_nxt = state;
      state_nxt = (state == INIT && last) ? RUN : state;
   end
   // one entry per INIT cycle: INV[FWD[i]] = i
   always_ff @(posedge clk) begin
      if (!rst && state == INIT) inv[ROTOR2_FWD[i]] <= i;
   end
   assign rd_data = inv[rd_addr];
   assign init_done = state == RUN;
endmodule

// File: rtl/rotor2_reverse.sv
// rotor2_reverse: return path through rotor II, x = (INV[y] - pos) mod 26,
// as a 2-stage valid/ready pipeline with backpressure.
module rotor2_reverse import rotor_pkg::*; #(
   parameter int ALPHA = 26,
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] data_in,
   input  logic [W-1:0] position,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] data_out,
   output logic         err_out,
   output logic         done_out,
   output logic         init_done
);
   localparam logic [W-1:0] A = W'(ALPHA);
   logic s1_valid, s1_bad, s2_adv, accept;
   logic [W-1:0] s1_y, s1_p, rd_addr, inv_y, mapped;
   logic [W:0] t;
   rotor2_inv_table #(.ALPHA(ALPHA), .W(W)) u_table (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(inv_y), .init_done(init_done));
   assign s2_adv = !out_valid || out_ready;
   assign in_ready = init_done && (!s1_valid || s2_adv);
   assign accept = in_valid && in_ready;
   // out-of-range letters never address the table
   assign rd_addr = s1_bad ? '0 : s1_y;
   assign t = {1'b0, inv_y} + {1'b0, A} - {1'b0, s1_p};
   assign mapped = t >= {1'b0, A} ? W'(t - {1'b0, A}) : t[W-1:0];
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_bad <= 1'b0;
         s1_y <= '0;
         s1_p <= '0;
         out_valid <= 1'b0;
         data_out <= '0;
         err_out <= 1'b0;
         done_out <= 1'b0;
      end else begin
         done_out <= out_valid && out_ready;
         if (accept) begin
            s1_valid <= 1'b1;
            s1_y <= data_in;
            s1_p <= position >= A ? position - A : position;
            s1_bad <= data_in >= A;
         end else if (s2_adv) begin
            s1_valid <= 1'b0;
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               data_out <= s1_bad ? W'(INVALID_LETTER) : mapped;
               err_out <= s1_bad;
            end
         end
      end
   end
endmodule

// File: tb/tb_rotor2_reverse.sv
// tb_rotor2_reverse: vector table plus scoreboard checks for the rotor II return stage.
module tb_rotor2_reverse;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic in_ready, out_valid, err_out, done_out, init_done;
   logic [4:0] data_in = 0, position = 0, data_out;
   int total = 0, bad = 0;
   logic [5:0] sb [$];
   logic mon_en = 0, last_emit = 0, rand_rdy = 0;
   typedef struct {logic [4:0] d; logic [4:0] p; logic [4:0] ed; logic ee;} vec_t;
   vec_t vt [9];
   logic [4:0] fwd [26] = '{6,11,16,24,22,1,19,8,25,3,15,18,5,10,0,13,9,2,20,23,17,4,21,12,14,7};

   rotor2_reverse dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .position(position), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
      .err_out(err_out), .done_out(done_out), .init_done(init_done));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         logic [5:0] e;
         chk("done_out", done_out, last_emit);
         if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: got data=%0d err=%0d expected none", data_out, err_out);
            end else begin
               e = sb.pop_front();
               chk("data_out", data_out, e[4:0]);
               chk("err_out", err_out, e[5]);
            end
         end
         last_emit = !rst && out_valid && out_ready;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = $urandom_range(0, 3) != 0;
   end

   task automatic send(input logic [4:0] d, input logic [4:0] p, input logic [4:0] ed, input logic ee);
      int n = 0;
      logic ok = 0;
      in_valid = 1;
      data_in = d;
      position = p;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = in_ready;
         if (ok) sb.push_back({ee, ed});
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
      end
      in_valid = 0;
      data_in = 5'($urandom);
      position = 5'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_left", sb.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      int low = 0;
      rst = 1;
      in_valid = 0;
      @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_err_out", err_out, 0);
      chk("rst_done_out", done_out, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_init_done", init_done, 0);
      @(posedge clk);
      #1;
      rst = 0;
      for (int k = 1; k <= 26; k++) begin
         @(negedge clk);
         if (!in_ready) low++;
         if (k == 26) chk("init_done_before_edge26", init_done, 0);
         @(posedge clk);
         #1;
      end
      chk("init_in_ready_low_cycles", low, 26);
      chk("init_done_at_edge26", init_done, 1);
      chk("in_ready_cycle27", in_ready, 1);
   endtask

   initial begin
      int acc;
      logic [4:0] hold;
      logic [4:0] bp_d [4];
      logic [4:0] bp_e [4];
      bp_d = '{0, 1, 2, 3};
      bp_e = '{14, 5, 17, 9};
      vt[0] = '{14, 0, 24, 0};
      vt[1] = '{6, 3, 23, 0};
      vt[2] = '{6, 29, 23, 0};
      vt[3] = '{26, 5, 31, 1};
      vt[4] = '{0, 0, 14, 0};
      vt[5] = '{25, 25, 9, 0};
      vt[6] = '{7, 31, 20, 0};
      vt[7] = '{31, 0, 31, 1};
      vt[8] = '{3, 0, 9, 0};

      do_reset();
      mon_en = 1;

      // latency and done_out timing for the first beat
      send(14, 0, 24, 0);
      chk("lat_cycle1_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_cycle2_out_valid", out_valid, 1);
      chk("lat_cycle2_data", data_out, 24);
      @(posedge clk);
      #1;
      chk("lat_done_pulse", done_out, 1);
      @(posedge clk);
      #1;
      chk("lat_done_cleared", done_out, 0);

      foreach (vt[k]) send(vt[k].d, vt[k].p, vt[k].ed, vt[k].ee);
      drain();

      // backpressure: only two beats fit while the output is stalled
      out_ready = 0;
      acc = 0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1;
         data_in = bp_d[acc];
         position = 0;
         @(negedge clk);
         if (in_ready) begin
            sb.push_back({1'b0, bp_e[acc]});
            acc++;
         end
         @(posedge clk);
         #1;
      end
      chk("bp_accepted", acc, 2);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      hold = data_out;
      @(posedge clk);
      #1;
      chk("bp_data_stable", data_out, hold);
      out_ready = 1;
      for (int k = 2; k < 4; k++) send(bp_d[k], 0, bp_e[k], 0);
      drain();

      // exhaustive round trip with random output stalls
      rand_rdy = 1;
      for (int x = 0; x < 26; x++)
         for (int p = 0; p < 26; p++)
            send(fwd[(x + p) % 26], 5'(p), 5'(x), 0);
      rand_rdy = 0;
      #1;
      out_ready = 1;
      drain();

      // reset with beats in flight: both are dropped, table rebuilt
      send(fwd[3], 0, 3, 0);
      send(fwd[4], 0, 4, 0);
      sb.delete();
      do_reset();
      for (int x = 0; x < 26; x += 5) send(fwd[(x + 7) % 26], 7, 5'(x), 0);
      send(6, 3, 23, 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
